// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial scheduler.
// Optional watchdog: FACT_SCHED_TIMEOUT_EN.
package fact_pkg;

    localparam int FACT_W       = 8;
    localparam int FACT_MAX_ARG = 5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } fact_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set req bit at or above ptr,
// wrapping at N_REQ, returned as one-hot plus index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;

    // Scan requesters starting at ptr; first hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N_REQ))
                sum = sum - (IDW+1)'(N_REQ);
            cand = sum[IDW-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fact_sched.sv
// Round-robin scheduler sharing one factorial engine among N_REQ clients.
// Optional WAIT watchdog enabled by defining FACT_SCHED_TIMEOUT_EN.
module fact_sched
    import fact_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MAX_ARG     = FACT_MAX_ARG,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*8-1:0]       req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [7:0]               rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     eng_start,
    output logic [7:0]               eng_data,
    input  logic [7:0]               eng_out,
    input  logic                     eng_done
);

    localparam int IDW = $clog2(N_REQ);

    fact_sched_state_t state, state_d;

    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    id_q;
    logic [FACT_W-1:0] op_q;
    logic              seen_low;

    logic [N_REQ-1:0]  arb_gnt;
    logic [IDW-1:0]    arb_idx;
    logic              arb_any;
    logic [FACT_W-1:0] win_op;
    logic              in_range;
    logic              take;
    logic              cap;

`ifdef FACT_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Select the winning requester's operand.
    always_comb begin
        win_op = '0;
        for (int k = 0; k < N_REQ; k++)
            if (arb_gnt[k])
                win_op = win_op | req_data[k*FACT_W +: FACT_W];
    end

    assign in_range = (int'(win_op) <= MAX_ARG);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next state, engine-facing strobes and handshake outputs.
    always_comb begin
        state_d   = state;
        take      = 1'b0;
        cap       = 1'b0;
`ifdef FACT_SCHED_TIMEOUT_EN
        tmo_hit   = 1'b0;
`endif
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        eng_start = 1'b0;
        eng_data  = '0;
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    take    = 1'b1;
                    state_d = in_range ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                eng_start = 1'b1;
                eng_data  = op_q;
                state_d   = WAIT;
            end
            WAIT: begin
                eng_data = op_q;
                if (eng_done && seen_low) begin
                    cap     = 1'b1;
                    state_d = RESP;
                end
`ifdef FACT_SCHED_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYC)) begin
                    tmo_hit = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch winner, track stale done, and hold the response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            rr_ptr   <= '0;
            id_q     <= '0;
            op_q     <= '0;
            seen_low <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            gnt <= take ? arb_gnt : '0;
            if (take) begin
                rr_ptr   <= (arb_idx == IDW'(N_REQ-1)) ? '0 : arb_idx + IDW'(1);
                id_q     <= arb_idx;
                op_q     <= win_op;
                rsp_data <= '0;
                rsp_err  <= !in_range;
            end
            if (state == ISSUE)
                seen_low <= 1'b0;
            else if (state == WAIT && !eng_done)
                seen_low <= 1'b1;
            if (cap) begin
                rsp_data <= eng_out;
                rsp_err  <= 1'b0;
            end
`ifdef FACT_SCHED_TIMEOUT_EN
            if (tmo_hit) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
`endif
        end
    end

`ifdef FACT_SCHED_TIMEOUT_EN
    // Watchdog: cleared on issue, counts while waiting on the engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              tmo_cnt <= '0;
        else if (state == ISSUE) tmo_cnt <= '0;
        else if (state == WAIT)  tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
`endif

    assign rsp_id = id_q;

endmodule

// File: tb/tb_fact_sched.sv
// Scoreboard bench for fact_sched with a behavioural factorial engine.
// Timeout scenario is built only when FACT_SCHED_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_fact_sched;

    localparam int N   = 4;
    localparam int TMO = 20;

    typedef struct {
        int id;
        int data;
        int err;
    } rsp_t;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_data;
    logic           rsp_err;
    logic           busy;
    logic           eng_start;
    logic [7:0]     eng_data;

    logic [7:0] eng_out  = 8'hEE;
    logic       eng_done = 1'b1;
    logic       eng_run  = 1'b0;
    int         eng_cnt  = 0;
    logic [7:0] eng_op   = 8'h00;
    bit         eng_stuck = 1'b0;
    int         stale_cyc = 0;

    int checks = 0;
    int errors = 0;
    int n_start = 0;

    rsp_t rsp_q[$];
    int   gnt_q[$];

    logic       hold_v = 1'b0;
    logic [1:0] hid;
    logic [7:0] hdata;
    logic       herr;

    fact_sched #(
        .N_REQ       (N),
        .MAX_ARG     (5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_data  (eng_data),
        .eng_out   (eng_out),
        .eng_done  (eng_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] fact8(input logic [7:0] n);
        int r;
        r = 1;
        for (int i = 2; i <= int'(n); i++) r = r * i;
        return r[7:0];
    endfunction

    // Engine without reset: done stays high for stale_cyc cycles after a
    // start, drops for 3 cycles, then rises with the result and stays high.
    always @(posedge clk) begin
        if (eng_start) begin
            eng_run <= 1'b1;
            eng_op  <= eng_data;
            eng_cnt <= 0;
        end else if (eng_run) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_stuck || (eng_cnt >= stale_cyc && eng_cnt < stale_cyc + 3)) begin
                eng_done <= 1'b0;
            end else if (eng_cnt >= stale_cyc + 3) begin
                eng_done <= 1'b1;
                eng_out  <= fact8(eng_op);
                eng_run  <= 1'b0;
            end
        end
    end

    always @(negedge clk)
        if (eng_start) n_start <= n_start + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: grant order, response scoreboard and hold stability.
    always @(negedge clk) begin
        int   ge;
        rsp_t re;
        if (rst_n) begin
            if (gnt != '0) begin
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 32'd0);
                end else begin
                    ge = gnt_q.pop_front();
                    chk("gnt_order", 32'(gnt), 32'(1 << ge));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    re = rsp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(re.id));
                    chk("rsp_data", 32'(rsp_data), 32'(re.data));
                    chk("rsp_err", 32'(rsp_err), 32'(re.err));
                end
            end
            if (rsp_valid && !rsp_ready) begin
                if (hold_v)
                    chk("rsp_hold", 32'({rsp_id, rsp_data, rsp_err}), 32'({hid, hdata, herr}));
                hold_v <= 1'b1;
                hid    <= rsp_id;
                hdata  <= rsp_data;
                herr   <= rsp_err;
            end else begin
                hold_v <= 1'b0;
            end
        end else begin
            hold_v <= 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [7:0] op);
        req_data[i*8 +: 8] = op;
        req[i] = 1'b1;
    endtask

    task automatic exp_rsp(input int id, input int data, input int err);
        rsp_t r;
        r.id = id;
        r.data = data;
        r.err = err;
        rsp_q.push_back(r);
    endtask

    task automatic drain(input int lim);
        int k;
        k = 0;
        while ((req != '0 || busy || rsp_q.size() != 0) && k < lim) begin
            @(posedge clk);
            #1;
            req = req & ~gnt;
            k++;
        end
        chk("drain_in_time", 32'(k < lim), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_start"}, 32'(eng_start), 32'd0);
        chk({tag, "_edata"}, 32'(eng_data), 32'd0);
        chk({tag, "_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rdata"}, 32'(rsp_data), 32'd0);
        chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        int s0;
        int k;
        rst_n = 1'b0;
        req = '0;
        req_data = '0;
        rsp_ready = 1'b1;
        cyc(3);
        chk_zero("reset");
        rst_n = 1'b1;
        cyc(2);

        // Single request: id 2, 4! = 24
        s0 = n_start;
        put(2, 8'd4);
        gnt_q.push_back(2);
        exp_rsp(2, 24, 0);
        drain(50);
        chk("t1_starts", 32'(n_start - s0), 32'd1);

        // Reset to rr_ptr 0, then all four contend
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        put(0, 8'd1);
        put(1, 8'd2);
        put(2, 8'd3);
        put(3, 8'd5);
        gnt_q.push_back(0); gnt_q.push_back(1);
        gnt_q.push_back(2); gnt_q.push_back(3);
        exp_rsp(0, 1, 0);
        exp_rsp(1, 2, 0);
        exp_rsp(2, 6, 0);
        exp_rsp(3, 120, 0);
        drain(200);

        put(0, 8'd3);
        put(3, 8'd4);
        gnt_q.push_back(0);
        gnt_q.push_back(3);
        exp_rsp(0, 6, 0);
        exp_rsp(3, 24, 0);
        drain(100);

        // Out-of-range operand: rejected without engine start
        s0 = n_start;
        put(1, 8'd6);
        gnt_q.push_back(1);
        exp_rsp(1, 0, 1);
        cyc(1);
        chk("t3_gnt", 32'(gnt), 32'h2);
        chk("t3_valid", 32'(rsp_valid), 32'd1);
        chk("t3_nostart", 32'(eng_start), 32'd0);
        req[1] = 1'b0;
        drain(20);
        chk("t3_starts", 32'(n_start - s0), 32'd0);

        // Operand 0 while done is still high from the last run
        stale_cyc = 3;
        put(2, 8'd0);
        gnt_q.push_back(2);
        exp_rsp(2, 1, 0);
        drain(50);
        stale_cyc = 0;

        // Backpressure with req[3] waiting
        rsp_ready = 1'b0;
        put(0, 8'd3);
        gnt_q.push_back(0);
        exp_rsp(0, 6, 0);
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(posedge clk);
            #1;
            req = req & ~gnt;
            k++;
        end
        chk("t5_valid_seen", 32'(rsp_valid), 32'd1);
        put(3, 8'd2);
        gnt_q.push_back(3);
        exp_rsp(3, 2, 0);
        repeat (10) begin
            cyc(1);
            chk("t5_no_gnt", 32'(gnt), 32'd0);
            chk("t5_held", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        cyc(1);
        chk("t5_acc_no_gnt", 32'(gnt), 32'd0);
        cyc(1);
        chk("t5_gnt3", 32'(gnt), 32'h8);
        req[3] = 1'b0;
        drain(50);

        // Reset during WAIT aborts the operation
        put(1, 8'd5);
        gnt_q.push_back(1);
        k = 0;
        while (!eng_start && k < 20) begin
            @(posedge clk);
            #1;
            req = req & ~gnt;
            k++;
        end
        chk("t6_started", 32'(eng_start), 32'd1);
        cyc(1);
        rst_n = 1'b0;
        #2;
        chk_zero("t6_rst");
        cyc(1);
        rst_n = 1'b1;
        cyc(15);
        chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);

        put(2, 8'd3);
        gnt_q.push_back(2);
        exp_rsp(2, 6, 0);
        drain(50);

`ifdef FACT_SCHED_TIMEOUT_EN
        eng_stuck = 1'b1;
        put(0, 8'd2);
        gnt_q.push_back(0);
        exp_rsp(0, 0, 1);
        drain(TMO + 60);
        eng_stuck = 1'b0;
        cyc(10);
        put(1, 8'd3);
        gnt_q.push_back(1);
        exp_rsp(1, 6, 0);
        drain(50);
`endif

        cyc(3);
        chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fact_sched.md
# fact_sched

Round-robin scheduler that shares one `factorial` engine among `N_REQ` requesters. It arbitrates requests and range-checks operands, issues a start to the engine, and qualifies the engine's done. It then returns the 8-bit result on a single tagged valid/ready response channel. It sits between client logic and the `factorial` instance and owns that instance's `start`/`Data_i` inputs.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `MAX_ARG`, default 5: largest operand whose factorial fits 8 bits.
- `TIMEOUT_CYC`, default 255: watchdog limit, in cycles; used only with `FACT_SCHED_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in `N_REQ`: request, one bit per requester; held high until the matching `gnt` bit.
- `req_data` in `N_REQ*8`: operand; requester i uses bits [8i+7:8i].
- `gnt` out `N_REQ`: one-hot, one-cycle acceptance pulse.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `$clog2(N_REQ)`: index of the requester that owns the response.
- `rsp_data` out 8: factorial result.
- `rsp_err` out 1: 1 = operand out of range, or timeout.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `eng_start` out 1: start pulse to the engine.
- `eng_data` out 8: operand to the engine.
- `eng_out` in 8: engine result.
- `eng_done` in 1: engine done; may stay high while the engine is idle.

## Operation
- FSM states:
  - IDLE. If any `req` bit is high, pick the winner round-robin, starting at `rr_ptr`. Latch its id and operand. Set `rr_ptr` to winner+1, wrapping at `N_REQ`. If operand > `MAX_ARG`, go to RESP with `rsp_err`=1 and `rsp_data`=0; otherwise go to ISSUE.
  - ISSUE. Drive `eng_start`=1 for exactly this cycle, then go to WAIT.
  - WAIT. Ignore `eng_done` until it has been sampled low at least once after the start; this discards a stale done. On the first qualified high, capture `eng_out` into `rsp_data`, set `rsp_err`=0, and go to RESP.
  - RESP. Hold `rsp_valid`=1 with `rsp_id`/`rsp_data`/`rsp_err` stable. When `rsp_valid && rsp_ready`, go to IDLE.
- Only one operation is in flight. A `req` that stays high after RESP is treated as a new request.
- `eng_data` holds the latched operand from ISSUE until leaving WAIT.
- Operand 0 is legal: the engine returns 1 and the scheduler passes it through unchanged.
- Equal-priority requests resolve in favour of the lowest index at or above `rr_ptr`.

## Timing
- Reset values: all outputs 0, `rr_ptr`=0, state IDLE. Reset asserted mid-operation aborts the operation, and no `gnt` or `rsp_valid` is produced for it. The engine has no reset, so the done qualification covers its stale state.
- `gnt` is registered. It is high in the first cycle after IDLE sampled `req`, which is the ISSUE cycle, or the first RESP cycle for a rejected operand.
- Latency for an in-range operand: req sampled at cycle 0 → `eng_start` at cycle 1 → `rsp_valid` one cycle after the qualified `eng_done`.
- Latency for an out-of-range operand: req sampled at cycle 0 → `rsp_valid` at cycle 1.
- Back-to-back operation: after response acceptance in cycle k, IDLE samples `req` in cycle k+1.
- Simultaneous `rsp_ready` and new `req` in RESP: the response completes, and the request waits for IDLE.

## Configuration
- `FACT_SCHED_TIMEOUT_EN` defined:
  - A counter is cleared in ISSUE and increments in WAIT.
  - When it reaches `TIMEOUT_CYC`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - A late `eng_done` is then ignored by the next operation's qualification.
- Not defined: no counter, and WAIT waits indefinitely.

## Structure
- Shared package `fact_pkg`:
  - state enum `fact_sched_state_t` (IDLE, ISSUE, WAIT, RESP);
  - constant `FACT_W`=8;
  - constant `FACT_MAX_ARG`=5.
- One sub-module, `rr_arbiter`: combinational round-robin pick of a one-hot winner from `req` and `rr_ptr`.
- Top-level wiring: `fact_sched` drives `factorial.start`/`Data_i` and consumes `Out`/`done`.

## Test plan
- Single request: req[2]=1, operand 4 → `gnt`=4'b0100 for one cycle, one `eng_start` pulse, then `rsp_valid` with id 2, `rsp_data`=24, `rsp_err`=0.
- All four requesters assert after reset, operands 1, 2, 3, 5 → grants in order 0, 1, 2, 3, results 1, 2, 6, 120. Then re-assert only req[0] and req[3] → grant order 0, 3.
- Operand 6 from req[1] → no `eng_start`, `rsp_valid` one cycle after sampling, `rsp_err`=1, `rsp_data`=0.
- Operand 0 with engine `done` held high from the previous run → result not captured until done falls and rises again, `rsp_data`=1.
- `rsp_ready` held low for 10 cycles with req[3] pending → response stable throughout; no `gnt[3]` until one cycle after acceptance.
- `rst_n` pulsed low during WAIT → all outputs 0; the stale done after reset produces no response. With `FACT_SCHED_TIMEOUT_EN` and `eng_done` stuck low → `rsp_err`=1 after `TIMEOUT_CYC` cycles.
